// File: rtl/y_requant_fifo_if.sv
// Handshake bundle between the conv_8_4 output stage and the requantizer FIFO.
// The slave modport is the FIFO's view; the master modport is the view of
// whoever drives y samples in and consumes requantized samples out.
interface y_requant_fifo_if;
    logic signed [17:0] s_data_in_y;
    logic               s_valid_y;
    logic               s_ready_y;
    logic signed [7:0]  m_data_out_q;
    logic               m_valid_q;
    logic               m_ready_q;
    logic               m_last_q;

    modport slave (
        input  s_data_in_y,
        input  s_valid_y,
        output s_ready_y,
        output m_data_out_q,
        output m_valid_q,
        input  m_ready_q,
        output m_last_q
    );

    modport master (
        output s_data_in_y,
        output s_valid_y,
        input  s_ready_y,
        input  m_data_out_q,
        input  m_valid_q,
        output m_ready_q,
        input  m_last_q
    );
endinterface

// File: rtl/y_requant_fifo.sv
// Requantizes 18-bit convolution results to signed 8-bit (optional ReLU,
// rounded arithmetic shift, saturation) and buffers them in a small FIFO
// tagged with end-of-frame flags. Also counts saturated samples.
module y_requant_fifo #(
    parameter int DEPTH     = 4,
    parameter int SHIFT     = 4,
    parameter int RELU      = 1,
    parameter int FRAME_LEN = 5
) (
    input  logic              clk,
    input  logic              reset,
    y_requant_fifo_if.slave   bus,
    output logic [15:0]       sat_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int FW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int BIAS = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 0;

    localparam logic signed [19:0] BIAS_V     = 20'(BIAS);
    localparam logic [AW:0]        DEPTH_V    = (AW + 1)'(DEPTH);
    localparam logic [FW-1:0]      FRAME_LAST = FW'(FRAME_LEN - 1);

    logic [AW:0]        occupancy;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [FW-1:0]      frame_cnt;
    logic [7:0]         data_mem [DEPTH];
    logic               last_mem [DEPTH];

    logic signed [19:0] v_relu;
    logic signed [19:0] v_shift;
    logic [7:0]         q_val;
    logic               q_sat;
    logic               push;
    logic               pop;
    logic               push_last;

    // Input transform: ReLU, round-half-up shift, then clamp to int8.
    // The 20-bit intermediate has headroom for the rounding bias on the
    // largest 18-bit input, so the add never overflows.
    always_comb begin
        v_relu  = {{2{bus.s_data_in_y[17]}}, bus.s_data_in_y};
        if (RELU != 0 && bus.s_data_in_y[17]) begin
            v_relu = '0;
        end
        v_shift = (v_relu + BIAS_V) >>> SHIFT;
        q_val   = v_shift[7:0];
        q_sat   = 1'b0;
        if (v_shift > 20'sd127) begin
            q_val = 8'h7F;
            q_sat = 1'b1;
        end else if (v_shift < -20'sd128) begin
            q_val = 8'h80;
            q_sat = 1'b1;
        end
    end

    // Handshake and head-of-queue view, all derived from registered state so
    // s_ready_y never combinationally depends on m_ready_q.
    always_comb begin
        bus.s_ready_y    = (occupancy < DEPTH_V);
        bus.m_valid_q    = (occupancy != '0);
        bus.m_data_out_q = bus.m_valid_q ? data_mem[rd_ptr] : 8'sd0;
        bus.m_last_q     = bus.m_valid_q ? last_mem[rd_ptr] : 1'b0;
        push             = bus.s_valid_y && bus.s_ready_y;
        pop              = bus.m_valid_q && bus.m_ready_q;
        push_last        = (frame_cnt == FRAME_LAST);
    end

    // Control state: occupancy, pointers, frame position and the
    // saturation counter, which sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            sat_count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                frame_cnt <= push_last ? '0 : frame_cnt + 1'b1;
                if (q_sat && sat_count != 16'hFFFF) begin
                    sat_count <= sat_count + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array; stale contents are harmless because the head is masked
    // to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            data_mem[wr_ptr] <= q_val;
            last_mem[wr_ptr] <= push_last;
        end
    end

endmodule

// File: tb/tb_y_requant_fifo.sv
// Scoreboard bench for y_requant_fifo: two instances (ReLU off / ReLU on),
// directed stimulus with hand-computed results, independent output monitors.
module tb_y_requant_fifo;

    localparam int FRAME_LEN = 5;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] sat_a;
    logic [15:0] sat_b;

    y_requant_fifo_if bus_a ();
    y_requant_fifo_if bus_b ();

    exp_t q_a[$];
    exp_t q_b[$];
    int   fcnt_a;
    int   fcnt_b;
    int   checks;
    int   errors;
    bit   rand_ready;
    bit   ready_hold;

    y_requant_fifo #(.DEPTH(4), .SHIFT(4), .RELU(0), .FRAME_LEN(FRAME_LEN)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_a.slave),
        .sat_count (sat_a)
    );

    y_requant_fifo #(.DEPTH(4), .SHIFT(4), .RELU(1), .FRAME_LEN(FRAME_LEN)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_b.slave),
        .sat_count (sat_b)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready for instance b: either held or randomly toggled.
    always @(posedge clk) begin
        #1;
        bus_b.m_ready_q = rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor for instance a: compare every accepted output with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus_a.m_valid_q && bus_a.m_ready_q) begin
            if (q_a.size() == 0) begin
                check_output("a_unexpected_output", int'($signed(bus_a.m_data_out_q)), 9999);
            end else begin
                e = q_a.pop_front();
                check_output("a_data", int'($signed(bus_a.m_data_out_q)), e.data);
                check_output("a_last", int'(bus_a.m_last_q), int'(e.last));
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus_b.m_valid_q && bus_b.m_ready_q) begin
            if (q_b.size() == 0) begin
                check_output("b_unexpected_output", int'($signed(bus_b.m_data_out_q)), 9999);
            end else begin
                e = q_b.pop_front();
                check_output("b_data", int'($signed(bus_b.m_data_out_q)), e.data);
                check_output("b_last", int'(bus_b.m_last_q), int'(e.last));
            end
        end
    end

    // Offer one sample (called just after a rising edge) and record the
    // expected output once the FIFO is seen ready to take it.
    task automatic apply_stimulus(input bit use_a, input logic signed [17:0] y, input int exp_q);
        int   waited;
        bit   ready_now;
        exp_t e;
        waited = 0;
        if (use_a) begin
            bus_a.s_data_in_y = y;
            bus_a.s_valid_y   = 1'b1;
        end else begin
            bus_b.s_data_in_y = y;
            bus_b.s_valid_y   = 1'b1;
        end
        ready_now = use_a ? bus_a.s_ready_y : bus_b.s_ready_y;
        while (!ready_now && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
            ready_now = use_a ? bus_a.s_ready_y : bus_b.s_ready_y;
        end
        if (!ready_now) begin
            check_output("push_timeout", 0, 1);
        end else begin
            e.data = exp_q;
            if (use_a) begin
                e.last = (fcnt_a == FRAME_LEN - 1);
                fcnt_a = e.last ? 0 : fcnt_a + 1;
                q_a.push_back(e);
            end else begin
                e.last = (fcnt_b == FRAME_LEN - 1);
                fcnt_b = e.last ? 0 : fcnt_b + 1;
                q_b.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (use_a) begin
            bus_a.s_valid_y   = 1'b0;
            bus_a.s_data_in_y = 18'($urandom);
        end else begin
            bus_b.s_valid_y   = 1'b0;
            bus_b.s_data_in_y = 18'($urandom);
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus_a.s_valid_y = 1'b0;
        bus_b.s_valid_y = 1'b0;
        q_a.delete();
        q_b.delete();
        fcnt_a = 0;
        fcnt_b = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("drain_pending", q_a.size() + q_b.size(), 0);
    endtask

    task automatic check_idle_b(input string tag, input int exp_sat);
        check_output({tag, "_s_ready"}, int'(bus_b.s_ready_y), 1);
        check_output({tag, "_m_valid"}, int'(bus_b.m_valid_q), 0);
        check_output({tag, "_m_data"}, int'($signed(bus_b.m_data_out_q)), 0);
        check_output({tag, "_m_last"}, int'(bus_b.m_last_q), 0);
        check_output({tag, "_sat"}, int'(sat_b), exp_sat);
    endtask

    // Watchdog so the run always ends even if the design stalls.
    initial begin
        #(10 * 98000);
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        checks            = 0;
        errors            = 0;
        rand_ready        = 1'b0;
        ready_hold        = 1'b1;
        reset             = 1'b1;
        bus_a.s_valid_y   = 1'b0;
        bus_b.s_valid_y   = 1'b0;
        bus_a.s_data_in_y = '0;
        bus_b.s_data_in_y = '0;
        bus_a.m_ready_q   = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        $display("[TB] reset state");
        check_idle_b("rst_b", 0);
        check_output("rst_a_s_ready", int'(bus_a.s_ready_y), 1);
        check_output("rst_a_m_valid", int'(bus_a.m_valid_q), 0);
        check_output("rst_a_sat", int'(sat_a), 0);

        $display("[TB] ReLU on: -2800 -> 0, 3600 -> 127 (saturated)");
        apply_stimulus(1'b0, -18'sd2800, 0);
        apply_stimulus(1'b0, 18'sd3600, 127);
        wait_drain();
        check_output("relu_sat_count", int'(sat_b), 1);

        $display("[TB] ReLU off: 400, 24, -24, -2800 -> 25, 2, -1, -128");
        apply_stimulus(1'b1, 18'sd400, 25);
        apply_stimulus(1'b1, 18'sd24, 2);
        apply_stimulus(1'b1, -18'sd24, -1);
        apply_stimulus(1'b1, -18'sd2800, -128);
        wait_drain();
        check_output("norelu_sat_count", int'(sat_a), 1);

        $display("[TB] junk data with valid low");
        repeat (4) begin
            bus_b.s_data_in_y = 18'sh20000;
            @(posedge clk);
            #1;
        end
        check_idle_b("idle_junk", 1);

        $display("[TB] fill to full with ready low, fifth held, then drain");
        ready_hold = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 18'sd16, 1);
        apply_stimulus(1'b0, 18'sd32, 2);
        apply_stimulus(1'b0, 18'sd48, 3);
        apply_stimulus(1'b0, 18'sd64, 4);
        check_output("full_s_ready", int'(bus_b.s_ready_y), 0);
        fork
            apply_stimulus(1'b0, 18'sd80, 5);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #2;
                    check_output("held_s_ready", int'(bus_b.s_ready_y), 0);
                    check_output("held_m_data", int'($signed(bus_b.m_data_out_q)), 1);
                end
                ready_hold = 1'b1;
            end
        join
        wait_drain();

        $display("[TB] ten pushes with random valid/ready, last on 5 and 10");
        do_reset();
        rand_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            apply_stimulus(1'b0, 18'(16 * k), k);
        end
        wait_drain();
        rand_ready = 1'b0;
        ready_hold = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset with 3 buffered entries mid-frame");
        apply_stimulus(1'b0, 18'sd16, 1);
        apply_stimulus(1'b0, 18'sd32, 2);
        apply_stimulus(1'b0, 18'sd48, 3);
        check_output("pre_reset_m_valid", int'(bus_b.m_valid_q), 1);
        do_reset();
        check_idle_b("mid_reset", 0);
        ready_hold = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            apply_stimulus(1'b0, 18'(16 * k + 16), k + 1);
        end
        wait_drain();

        $display("[TB] saturation counter ceiling");
        for (int k = 0; k < 65535; k++) begin
            apply_stimulus(1'b0, 18'sd3600, 127);
        end
        check_output("sat_at_max", int'(sat_b), 65535);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b0, -18'sd2800, 0);
            apply_stimulus(1'b0, 18'sd100000, 127);
        end
        wait_drain();
        check_output("sat_held", int'(sat_b), 65535);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/y_requant_fifo.md
Y_REQUANT_FIFO -- requirements
Module: y_requant_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 Parameter SHIFT, default 4, arithmetic right-shift applied to y (0..8).
REQ-003 Parameter RELU, default 1, 1 = clamp negative y to 0 before shifting.
REQ-004 Parameter FRAME_LEN, default 5, outputs per convolution frame.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 s_data_in_y  input  18  signed convolution result from the conv_8_4 output port.
REQ-008 s_valid_y  input  1  upstream data valid.
REQ-009 s_ready_y  output  1  block can accept a sample.
REQ-010 m_data_out_q  output  8  signed requantized result.
REQ-011 m_valid_q  output  1  output data valid.
REQ-012 m_ready_q  input  1  downstream accepts output.
REQ-013 m_last_q  output  1  marks the final sample of a frame; qualified by m_valid_q.
REQ-014 sat_count  output  16  count of saturated accepted samples.

Function
REQ-015 Push occurs on an edge where s_valid_y && s_ready_y; pop occurs on an edge where m_valid_q && m_ready_q.
REQ-016 s_ready_y = (occupancy < DEPTH), combinational from registered occupancy only; it does not depend on m_ready_q.
REQ-017 m_valid_q = (occupancy > 0); m_data_out_q and m_last_q show the head entry; both read 0 when empty.
REQ-018 Transform is computed combinationally at the input and the stored entry holds the final 8-bit result plus its last flag.
REQ-019 Step 1: if RELU=1 and y<0, v=0; else v=y, sign-extended to 20 bits.
REQ-020 Step 2: if SHIFT>0, v = (v + 2^(SHIFT-1)) >>> SHIFT (round half up); if SHIFT=0, v unchanged.
REQ-021 Step 3: saturate v to [-128, 127]; a sample is saturated when clamping changed its value.
REQ-022 sat_count increments by 1 on each push of a saturated sample and holds at 16'hFFFF (no wrap).
REQ-023 Frame counter counts pushes 0..FRAME_LEN-1; a push at count FRAME_LEN-1 stores last=1 and wraps the counter to 0.
REQ-024 Latency: a push into an empty FIFO at edge N gives m_valid_q=1 from edge N; there is no bypass in the same cycle.
REQ-025 Simultaneous push and pop leave occupancy unchanged; write and read pointers both advance modulo DEPTH.
REQ-026 When full, push cannot occur; a pop in that cycle frees one slot, and s_ready_y rises the following cycle.
REQ-027 When empty, pop cannot occur; m_ready_q is ignored.
REQ-028 Output data is stable while m_valid_q=1 and m_ready_q=0.
REQ-029 Input X on s_data_in_y while s_valid_y=0 does not affect any state.

Reset
REQ-030 In a reset cycle, occupancy, pointers, frame counter and sat_count all become 0.
REQ-031 After reset: s_ready_y=1 (combinational from occupancy 0); m_valid_q=0, m_data_out_q=0, m_last_q=0, sat_count=0.
REQ-032 Reset mid-operation discards all buffered entries and the partial frame; no push or pop takes effect in a reset cycle.

Verification
REQ-033 SHIFT=4, RELU=0; inputs 400, 24, -24, -2800 -> outputs 25, 2, -1, -128 in order; sat_count=1.
REQ-034 RELU=1, SHIFT=4; inputs -2800, 3600 -> outputs 0, 127; sat_count=1 (3600->225 clamped).
REQ-035 m_ready_q=0, push 5 back-to-back -> s_ready_y falls after the 4th push and the 5th is held; then m_ready_q=1 -> all 5 drain in order with no loss or duplication.
REQ-036 10 pushes with random valid/ready -> m_last_q=1 only on outputs 5 and 10.
REQ-037 Assert reset with 3 entries buffered and frame count 3 -> next cycle m_valid_q=0 and s_ready_y=1; a further 5 pushes give m_last_q on the 5th.
REQ-038 Saturate 65536+ samples -> sat_count holds at 65535.
